mul16_wallace_seq: RTL and testbench

- Sequential 16x16 unsigned multiplier built around the existing 8x8 `wallace` combinational multiplier, which it time-shares.
- Feeds the single multiplier the four byte cross-products over four cycles, shifts each result and adds it into a 32-bit accumulator.
- Uses valid/ready handshakes on both sides, so it can be dropped into streaming datapaths that need a wider product than `wallace` gives directly.

---
 rtl/mul16_pkg.sv | 18 +
 rtl/wallace.sv | 39 +++
 rtl/mul16_wallace_seq.sv | 151 +++++++++++++++
 tb/tb_mul16_wallace_seq.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/mul16_pkg.sv
// Shared widths and FSM state encoding for the sequential 16x16 multiplier.
package mul16_pkg;

  localparam int OP_W    = 16;
  localparam int BYTE_W  = 8;
  localparam int PROD_W  = 32;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_LL   = 3'd1,
    ST_LH   = 3'd2,
    ST_HL   = 3'd3,
    ST_HH   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/wallace.sv
// 8x8 unsigned combinational multiplier: partial products reduced by a
// tree of 3:2 carry-save adders, finished with one carry-propagate add.
module wallace (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  // Carry-save compressor: returns {carry, sum}; arithmetic is modulo 2^16,
  // which is exact because the full product always fits in 16 bits.
  function automatic logic [31:0] csa(input logic [15:0] x,
                                      input logic [15:0] y,
                                      input logic [15:0] z);
    logic [15:0] s;
    logic [15:0] c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {c, s};
  endfunction

  logic [15:0] pp_s [8];
  logic [31:0] c0_s, c1_s, c2_s, c3_s, c4_s, c5_s;

  // Partial-product generation
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pp_s[i] = {8'h00, a & {8{b[i]}}} << i;
    end
  end

  assign c0_s = csa(pp_s[0], pp_s[1], pp_s[2]);
  assign c1_s = csa(pp_s[3], pp_s[4], pp_s[5]);
  assign c2_s = csa(c0_s[15:0], c0_s[31:16], c1_s[15:0]);
  assign c3_s = csa(c1_s[31:16], pp_s[6], pp_s[7]);
  assign c4_s = csa(c2_s[15:0], c2_s[31:16], c3_s[15:0]);
  assign c5_s = csa(c4_s[15:0], c4_s[31:16], c3_s[31:16]);
  assign p    = c5_s[15:0] + c5_s[31:16];

endmodule

// File: rtl/mul16_wallace_seq.sv
// Sequential 16x16 unsigned multiplier time-sharing one 8x8 wallace core.
// Optional MUL16_ZERO_SKIP_EN: zero operands bypass the compute states.
module mul16_wallace_seq
  import mul16_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product,
  output logic              busy,
  output logic [CNT_W-1:0]  ops_done
);

  state_t              state_r, state_next_s;
  logic [OP_W-1:0]     a_r, b_r;
  logic [PROD_W-1:0]   acc_r, product_r;
  logic [PROD_W-1:0]   addend_s, acc_sum_s;
  logic [BYTE_W-1:0]   mul_a_s, mul_b_s;
  logic [2*BYTE_W-1:0] mul_p_s;
  logic [CNT_W-1:0]    ops_done_r;
  logic                accept_s, skip_s;

  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = (state_r == ST_DONE);
  assign busy      = (state_r != ST_IDLE);
  assign product   = product_r;
  assign ops_done  = ops_done_r;
  assign accept_s  = in_valid && (state_r == ST_IDLE);

`ifdef MUL16_ZERO_SKIP_EN
  assign skip_s = (a == {OP_W{1'b0}}) || (b == {OP_W{1'b0}});
`else
  assign skip_s = 1'b0;
`endif

  // Byte-select mux feeding the shared multiplier; idle inputs stay at zero
  always_comb begin
    mul_a_s = {BYTE_W{1'b0}};
    mul_b_s = {BYTE_W{1'b0}};
    case (state_r)
      ST_LL:   begin mul_a_s = a_r[7:0];  mul_b_s = b_r[7:0];  end
      ST_LH:   begin mul_a_s = a_r[7:0];  mul_b_s = b_r[15:8]; end
      ST_HL:   begin mul_a_s = a_r[15:8]; mul_b_s = b_r[7:0];  end
      ST_HH:   begin mul_a_s = a_r[15:8]; mul_b_s = b_r[15:8]; end
      default: begin mul_a_s = {BYTE_W{1'b0}}; mul_b_s = {BYTE_W{1'b0}}; end
    endcase
  end

  wallace u_wallace (
    .a (mul_a_s),
    .b (mul_b_s),
    .p (mul_p_s)
  );

  // Zero-extend the partial product, then align it to its byte weight
  always_comb begin
    addend_s = {PROD_W{1'b0}};
    case (state_r)
      ST_LL:        addend_s = {16'h0000, mul_p_s};
      ST_LH, ST_HL: addend_s = {8'h00, mul_p_s, 8'h00};
      ST_HH:        addend_s = {mul_p_s, 16'h0000};
      default:      addend_s = {PROD_W{1'b0}};
    endcase
  end

  assign acc_sum_s = acc_r + addend_s;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = skip_s ? ST_DONE : ST_LL;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LL:   state_next_s = ST_LH;
      ST_LH:   state_next_s = ST_HL;
      ST_HL:   state_next_s = ST_HH;
      ST_HH:   state_next_s = ST_DONE;
      ST_DONE: begin
        if (out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Operand capture, accumulation, result hand-off and operation counting.
  // product_r is loaded only when a result completes, so it holds its value
  // while the accumulator is cleared and reused by the next operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r        <= {OP_W{1'b0}};
      b_r        <= {OP_W{1'b0}};
      acc_r      <= {PROD_W{1'b0}};
      product_r  <= {PROD_W{1'b0}};
      ops_done_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            a_r   <= a;
            b_r   <= b;
            acc_r <= {PROD_W{1'b0}};
            if (skip_s) begin
              product_r <= {PROD_W{1'b0}};
            end
          end
        end
        ST_LL, ST_LH, ST_HL: begin
          acc_r <= acc_sum_s;
        end
        ST_HH: begin
          acc_r     <= acc_sum_s;
          product_r <= acc_sum_s;
        end
        ST_DONE: begin
          if (out_ready) begin
            ops_done_r <= ops_done_r + CNT_W'(1);
          end
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul16_wallace_seq.sv
// Directed scoreboard bench for mul16_wallace_seq; a second instance with a
// 2-bit counter shares the stimulus to exercise ops_done wrap-around.
module tb_mul16_wallace_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a, b;
  logic        in_ready, out_valid, busy;
  logic [31:0] product;
  logic [15:0] ops_done;
  logic        in_ready2, out_valid2, busy2;
  logic [31:0] product2;
  logic [1:0]  ops_done2;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [15:0] ops_exp = 16'd0;
  logic [1:0]  ops_exp2 = 2'd0;

  mul16_wallace_seq #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy), .ops_done(ops_done)
  );

  mul16_wallace_seq #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .out_valid(out_valid2), .out_ready(out_ready),
    .product(product2), .busy(busy2), .ops_done(ops_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv,
                        input logic [31:0] exp_p, input int stall);
    int          lat;
    int          exp_lat;
    logic [31:0] exp_v;
    exp_lat = 5;
`ifdef MUL16_ZERO_SKIP_EN
    if (ta == 16'd0 || tbv == 16'd0) exp_lat = 1;
`endif
    @(negedge clk);
    a = ta; b = tbv; in_valid = 1'b1; out_ready = (stall == 0);
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    exp_q.push_back(exp_p);
    #1;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
    // Operand noise while busy must not disturb the result
    a = 16'($urandom); b = 16'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, exp_lat);
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check("product", product, exp_v);
    check("product_cnt2", product2, exp_v);
    check("in_ready_done", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
      @(posedge clk); #1;
      check("held_valid", {31'd0, out_valid}, 32'd1);
      check("held_product", product, exp_v);
      check("held_in_ready", {31'd0, in_ready}, 32'd0);
      check("held_ops", {16'd0, ops_done}, {16'd0, ops_exp});
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    ops_exp  = ops_exp + 16'd1;
    ops_exp2 = ops_exp2 + 2'd1;
    check("ops_done", {16'd0, ops_done}, {16'd0, ops_exp});
    check("ops_done_cnt2", {30'd0, ops_done2}, {30'd0, ops_exp2});
    check("valid_after_handoff", {31'd0, out_valid}, 32'd0);
    check("in_ready_after_handoff", {31'd0, in_ready}, 32'd1);
    check("product_holds", product, exp_v);
  endtask

  initial begin
    logic [15:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = 16'd0; b = 16'd0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_product", product, 32'd0);
    check("rst_ops_done", {16'd0, ops_done}, 32'd0);
    check("rst_cnt2_flags", {29'd0, out_valid2, busy2, in_ready2}, 32'd1);
    rst = 1'b0;

    run_op(16'h1234, 16'h5678, 32'h0626_0060, 0);
    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 0);
    run_op(16'h00FF, 16'h0100, 32'h0000_FF00, 0);
    run_op(16'h0003, 16'h0005, 32'h0000_000F, 10);
    run_op(16'h0000, 16'hABCD, 32'h0000_0000, 0);

    // Abort an operation while it is in LH
    @(negedge clk);
    a = 16'h0102; b = 16'h0304; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_product", product, 32'd0);
    check("abort_ops_done", {16'd0, ops_done}, 32'd0);
    check("abort_ops_cnt2", {30'd0, ops_done2}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ops_exp = 16'd0; ops_exp2 = 2'd0;

    // Four back-to-back ops: the 2-bit counter walks 1,2,3,0
    run_op(16'h0002, 16'h0007, 32'h0000_000E, 0);
    for (int k = 0; k < 3; k++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      run_op(ra, rb, {16'd0, ra} * {16'd0, rb}, k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
